carousel_rotator: RTL and testbench

Parametrised N-channel gather/rotate/scatter buffer. The block collects one word per input channel under independent valid/ready handshakes. It then rotates the channel contents by a run-time amount and direction, and dispenses them on independent output handshakes. The rotate-and-dispense pass can repeat for a programmable number of rounds before the block accepts new data. It sits between parallel lane streams in the datapath wherever lane data must be cyclically permuted, such as systolic operand re-use and lane realignment.

---
 rtl/carousel_rotator.sv | 147 ++++++++++++++
 tb/tb_carousel_rotator.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/carousel_rotator.sv
// carousel_rotator: N-channel gather / rotate / scatter buffer.
// Words are collected one per channel under independent handshakes. The
// stored set is then cyclically rotated and dispensed on independent output
// handshakes. The rotate-and-dispense pass repeats for a latched number of
// rounds, and the rotation accumulates from one round to the next.
module carousel_rotator #(
  parameter  int DATA_WIDTH   = 8,
  parameter  int NUM_CHANNELS = 4,
  parameter  int ROUND_WIDTH  = 4,
  localparam int AMT_WIDTH    = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]  data_in,
  input  logic [NUM_CHANNELS-1:0]                  data_in_valid,
  output logic [NUM_CHANNELS-1:0]                  data_in_ready,
  output logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0]  data_out,
  output logic [NUM_CHANNELS-1:0]                  data_out_valid,
  input  logic [NUM_CHANNELS-1:0]                  data_out_ready,
  input  logic [AMT_WIDTH-1:0]                     rotate_amount,
  input  logic                                     rotate_left,
  input  logic [ROUND_WIDTH-1:0]                   rounds,
  output logic                                     busy
);

  typedef enum logic [1:0] {
    ST_GATHER   = 2'd0,
    ST_ROTATE   = 2'd1,
    ST_DISPENSE = 2'd2
  } state_t;

  state_t                                  state_q;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] data_q;
  logic [NUM_CHANNELS-1:0]                 captured_q;
  logic [NUM_CHANNELS-1:0]                 dispensed_q;
  logic [ROUND_WIDTH-1:0]                  round_q;
  logic [AMT_WIDTH-1:0]                    amt_q;
  logic                                    left_q;
  logic [ROUND_WIDTH-1:0]                  rounds_q;

  logic [NUM_CHANNELS-1:0]                 in_fire;
  logic [NUM_CHANNELS-1:0]                 out_fire;
  logic                                    gather_done;
  logic                                    dispense_done;
  logic [AMT_WIDTH-1:0]                    k_mod;
  logic [ROUND_WIDTH-1:0]                  eff_rounds;
  logic                                    last_round;
  logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] rot_d;

  // Handshake qualifiers. Ready is forced low while reset is held so every
  // output reads zero during reset, not just the registered ones.
  always_comb begin
    data_in_ready  = '0;
    data_out_valid = '0;
    if (state_q == ST_GATHER && !rst) begin
      data_in_ready = ~captured_q;
    end
    if (state_q == ST_DISPENSE) begin
      data_out_valid = ~dispensed_q;
    end
  end

  assign in_fire       = data_in_valid & data_in_ready;
  assign out_fire      = data_out_valid & data_out_ready;
  assign gather_done   = &(captured_q | in_fire);
  assign dispense_done = &(dispensed_q | out_fire);

  assign data_out = data_q;
  assign busy     = (state_q != ST_GATHER);

  // Rotation distance reduced modulo N (matters only for non-power-of-two N).
  assign k_mod = AMT_WIDTH'(32'(amt_q) % 32'(NUM_CHANNELS));

  // A programmed round count of zero still performs one pass.
  assign eff_rounds = (rounds_q == '0) ? ROUND_WIDTH'(1) : rounds_q;
  assign last_round = (round_q >= (eff_rounds - ROUND_WIDTH'(1)));

  // Rotation network: each destination channel picks among all N possible
  // sources with constant indices, selected by the reduced distance.
  generate
    for (genvar gi = 0; gi < NUM_CHANNELS; gi++) begin : g_ch
      logic [NUM_CHANNELS-1:0][DATA_WIDTH-1:0] cand;
      for (genvar gs = 0; gs < NUM_CHANNELS; gs++) begin : g_src
        localparam int LI = (gi + gs) % NUM_CHANNELS;
        localparam int RI = (gi - gs + NUM_CHANNELS) % NUM_CHANNELS;
        assign cand[gs] = left_q ? data_q[LI] : data_q[RI];
      end
      assign rot_d[gi] = cand[k_mod];
    end
  endgenerate

  // Control FSM and datapath registers: gather, one-cycle rotate, dispense,
  // looping back to rotate until the latched round count is exhausted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_GATHER;
      data_q      <= '0;
      captured_q  <= '0;
      dispensed_q <= '0;
      round_q     <= '0;
      amt_q       <= '0;
      left_q      <= 1'b0;
      rounds_q    <= '0;
    end else begin
      case (state_q)
        ST_GATHER: begin
          for (int i = 0; i < NUM_CHANNELS; i++) begin
            if (in_fire[i]) begin
              data_q[i] <= data_in[i];
            end
          end
          captured_q <= captured_q | in_fire;
          if (gather_done) begin
            // Configuration is sampled only here; later changes are ignored
            // until the next gather completes.
            amt_q    <= rotate_amount;
            left_q   <= rotate_left;
            rounds_q <= rounds;
            state_q  <= ST_ROTATE;
          end
        end
        ST_ROTATE: begin
          data_q      <= rot_d;
          dispensed_q <= '0;
          state_q     <= ST_DISPENSE;
        end
        ST_DISPENSE: begin
          dispensed_q <= dispensed_q | out_fire;
          if (dispense_done) begin
            if (!last_round) begin
              round_q <= round_q + ROUND_WIDTH'(1);
              state_q <= ST_ROTATE;
            end else begin
              captured_q <= '0;
              round_q    <= '0;
              state_q    <= ST_GATHER;
            end
          end
        end
        default: begin
          state_q <= ST_GATHER;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_carousel_rotator.sv
// Directed testbench for carousel_rotator with N=4, 8-bit words.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_carousel_rotator;

  logic            clk = 1'b0;
  logic            rst;
  logic [3:0][7:0] data_in;
  logic [3:0]      data_in_valid;
  logic [3:0]      data_in_ready;
  logic [3:0][7:0] data_out;
  logic [3:0]      data_out_valid;
  logic [3:0]      data_out_ready;
  logic [1:0]      rotate_amount;
  logic            rotate_left;
  logic [3:0]      rounds;
  logic            busy;

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  carousel_rotator #(
    .DATA_WIDTH  (8),
    .NUM_CHANNELS(4),
    .ROUND_WIDTH (4)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .data_in       (data_in),
    .data_in_valid (data_in_valid),
    .data_in_ready (data_in_ready),
    .data_out      (data_out),
    .data_out_valid(data_out_valid),
    .data_out_ready(data_out_ready),
    .rotate_amount (rotate_amount),
    .rotate_left   (rotate_left),
    .rounds        (rounds),
    .busy          (busy)
  );

  // Present all four words in one cycle; returns at the falling edge that
  // follows the capture edge (block is then in its rotate cycle).
  task automatic drive_all(input logic [31:0] vals, input logic [1:0] amt,
                           input logic left, input logic [3:0] rnds);
    @(negedge clk);
    data_in       = vals;
    data_in_valid = 4'hF;
    rotate_amount = amt;
    rotate_left   = left;
    rounds        = rnds;
    @(negedge clk);
    data_in_valid = 4'h0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #2;
    vec_cnt++;
    if ({data_in_ready, data_out_valid, busy} !== 9'd0) begin
      err_cnt++;
      $display("FAIL reset_ctrl: got rdy=%b vld=%b busy=%b, want all 0",
               data_in_ready, data_out_valid, busy);
    end
    vec_cnt++;
    if (data_out !== 32'h0) begin
      err_cnt++;
      $display("FAIL reset_data: got %h, want 00000000", data_out);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vec_cnt++;
    if (data_in_ready !== 4'hF) begin
      err_cnt++;
      $display("FAIL reset_release_ready: got %b, want 1111", data_in_ready);
    end
    $display("test_reset done");
  endtask

  task automatic test_basic_left;
    data_out_ready = 4'hF;
    drive_all({8'h13, 8'h12, 8'h11, 8'h10}, 2'd1, 1'b1, 4'd1);
    vec_cnt++;
    if (data_out_valid !== 4'h0 || data_in_ready !== 4'h0 || busy !== 1'b1) begin
      err_cnt++;
      $display("FAIL basic_rotate_cycle: vld=%b rdy=%b busy=%b, want 0000 0000 1",
               data_out_valid, data_in_ready, busy);
    end
    @(negedge clk);
    vec_cnt++;
    if (data_out_valid !== 4'hF || data_out !== {8'h10, 8'h13, 8'h12, 8'h11}) begin
      err_cnt++;
      $display("FAIL basic_dispense: vld=%b data=%h, want 1111 10131211",
               data_out_valid, data_out);
    end
    @(negedge clk);
    vec_cnt++;
    if (data_in_ready !== 4'hF || data_out_valid !== 4'h0 || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL basic_return: rdy=%b vld=%b busy=%b, want 1111 0000 0",
               data_in_ready, data_out_valid, busy);
    end
    $display("test_basic_left done");
  endtask

  task automatic test_staggered_right;
    data_out_ready = 4'hF;
    // Config presented early must be ignored; only the final-capture cycle counts.
    rotate_amount = 2'd2;
    rotate_left   = 1'b1;
    rounds        = 4'd1;
    @(negedge clk);
    data_in       = {8'h00, 8'h12, 8'h00, 8'h00};
    data_in_valid = 4'b0100;
    @(negedge clk);
    vec_cnt++;
    if (data_in_ready !== 4'b1011) begin
      err_cnt++;
      $display("FAIL stag_after_ch2: rdy=%b, want 1011", data_in_ready);
    end
    // ch2 stays valid with a different word; it must not be recaptured.
    data_in       = {8'h13, 8'hEE, 8'h00, 8'h00};
    data_in_valid = 4'b1100;
    @(negedge clk);
    vec_cnt++;
    if (data_in_ready !== 4'b0011) begin
      err_cnt++;
      $display("FAIL stag_after_ch3: rdy=%b, want 0011", data_in_ready);
    end
    data_in_valid = 4'b0100;
    @(negedge clk);
    vec_cnt++;
    if (data_in_ready !== 4'b0011 || data_out_valid !== 4'h0) begin
      err_cnt++;
      $display("FAIL stag_gap: rdy=%b vld=%b, want 0011 0000",
               data_in_ready, data_out_valid);
    end
    data_in       = {8'h13, 8'hEE, 8'h11, 8'h00};
    data_in_valid = 4'b0110;
    @(negedge clk);
    vec_cnt++;
    if (data_in_ready !== 4'b0001 || data_out_valid !== 4'h0) begin
      err_cnt++;
      $display("FAIL stag_after_ch1: rdy=%b vld=%b, want 0001 0000",
               data_in_ready, data_out_valid);
    end
    data_in       = {8'h13, 8'hEE, 8'h11, 8'h10};
    data_in_valid = 4'b0101;
    rotate_amount = 2'd1;
    rotate_left   = 1'b0;
    @(negedge clk);
    data_in_valid = 4'b0000;
    rotate_amount = 2'd3;
    rotate_left   = 1'b1;
    vec_cnt++;
    if (data_out_valid !== 4'h0 || busy !== 1'b1) begin
      err_cnt++;
      $display("FAIL stag_rotate_cycle: vld=%b busy=%b, want 0000 1",
               data_out_valid, busy);
    end
    @(negedge clk);
    vec_cnt++;
    if (data_out_valid !== 4'hF || data_out !== {8'h12, 8'h11, 8'h10, 8'h13}) begin
      err_cnt++;
      $display("FAIL stag_dispense: vld=%b data=%h, want 1111 12111013",
               data_out_valid, data_out);
    end
    @(negedge clk);
    vec_cnt++;
    if (data_in_ready !== 4'hF) begin
      err_cnt++;
      $display("FAIL stag_return: rdy=%b, want 1111", data_in_ready);
    end
    $display("test_staggered_right done");
  endtask

  task automatic test_multi_round;
    logic [3:0][7:0] exp_pass [3];
    exp_pass[0] = {8'h10, 8'h13, 8'h12, 8'h11};
    exp_pass[1] = {8'h11, 8'h10, 8'h13, 8'h12};
    exp_pass[2] = {8'h12, 8'h11, 8'h10, 8'h13};
    data_out_ready = 4'hF;
    drive_all({8'h13, 8'h12, 8'h11, 8'h10}, 2'd1, 1'b1, 4'd3);
    for (int p = 0; p < 3; p++) begin
      @(negedge clk);
      // Changing the rotation config mid-operation must not matter.
      rotate_amount = 2'd3;
      rotate_left   = 1'b0;
      vec_cnt++;
      if (data_out_valid !== 4'hF || data_out !== exp_pass[p]) begin
        err_cnt++;
        $display("FAIL multi_pass%0d: vld=%b data=%h, want 1111 %h",
                 p, data_out_valid, data_out, exp_pass[p]);
      end
      @(negedge clk);
      if (p < 2) begin
        vec_cnt++;
        if (data_out_valid !== 4'h0 || busy !== 1'b1 || data_in_ready !== 4'h0) begin
          err_cnt++;
          $display("FAIL multi_gap%0d: vld=%b busy=%b rdy=%b, want 0000 1 0000",
                   p, data_out_valid, busy, data_in_ready);
        end
      end else begin
        vec_cnt++;
        if (data_in_ready !== 4'hF || busy !== 1'b0) begin
          err_cnt++;
          $display("FAIL multi_return: rdy=%b busy=%b, want 1111 0",
                   data_in_ready, busy);
        end
      end
    end
    $display("test_multi_round done");
  endtask

  task automatic test_backpressure;
    data_out_ready = 4'b1101;
    drive_all({8'h13, 8'h12, 8'h11, 8'h10}, 2'd1, 1'b1, 4'd2);
    @(negedge clk);
    vec_cnt++;
    if (data_out_valid !== 4'hF) begin
      err_cnt++;
      $display("FAIL bp_first: vld=%b, want 1111", data_out_valid);
    end
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      vec_cnt++;
      if (data_out_valid !== 4'b0010 || data_out[1] !== 8'h12 ||
          busy !== 1'b1 || data_in_ready !== 4'h0) begin
        err_cnt++;
        $display("FAIL bp_hold%0d: vld=%b ch1=%h busy=%b rdy=%b, want 0010 12 1 0000",
                 c, data_out_valid, data_out[1], busy, data_in_ready);
      end
    end
    data_out_ready = 4'hF;
    @(negedge clk);
    // Round 1 of 2 is done: expect the rotate cycle, not gather.
    vec_cnt++;
    if (data_out_valid !== 4'h0 || busy !== 1'b1) begin
      err_cnt++;
      $display("FAIL bp_rotate: vld=%b busy=%b, want 0000 1",
               data_out_valid, busy);
    end
    @(negedge clk);
    vec_cnt++;
    if (data_out_valid !== 4'hF || data_out !== {8'h11, 8'h10, 8'h13, 8'h12}) begin
      err_cnt++;
      $display("FAIL bp_round2: vld=%b data=%h, want 1111 11101312",
               data_out_valid, data_out);
    end
    @(negedge clk);
    $display("test_backpressure done");
  endtask

  task automatic test_modulo_edges;
    int amt4;
    amt4 = 4;
    data_out_ready = 4'hF;
    // Distance 4 on four channels is identity; rounds 0 acts as one round.
    drive_all({8'hA3, 8'hA2, 8'hA1, 8'hA0}, 2'(amt4), 1'b1, 4'd0);
    @(negedge clk);
    vec_cnt++;
    if (data_out_valid !== 4'hF || data_out !== {8'hA3, 8'hA2, 8'hA1, 8'hA0}) begin
      err_cnt++;
      $display("FAIL mod_identity: vld=%b data=%h, want 1111 a3a2a1a0",
               data_out_valid, data_out);
    end
    @(negedge clk);
    vec_cnt++;
    if (data_in_ready !== 4'hF || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL rounds0_single: rdy=%b busy=%b, want 1111 0",
               data_in_ready, busy);
    end
    $display("test_modulo_edges done");
  endtask

  task automatic test_reset_mid_dispense;
    data_out_ready = 4'h0;
    drive_all({8'h13, 8'h12, 8'h11, 8'h10}, 2'd1, 1'b1, 4'd1);
    @(negedge clk);
    @(negedge clk);
    vec_cnt++;
    if (data_out_valid !== 4'hF) begin
      err_cnt++;
      $display("FAIL mid_precond: vld=%b, want 1111", data_out_valid);
    end
    rst = 1'b1;
    #1;
    vec_cnt++;
    if ({data_in_ready, data_out_valid, busy} !== 9'd0 || data_out !== 32'h0) begin
      err_cnt++;
      $display("FAIL mid_reset_outputs: rdy=%b vld=%b busy=%b data=%h, want all 0",
               data_in_ready, data_out_valid, busy, data_out);
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    vec_cnt++;
    if (data_in_ready !== 4'hF || data_out !== 32'h0 || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL mid_reset_release: rdy=%b data=%h busy=%b, want 1111 00000000 0",
               data_in_ready, data_out, busy);
    end
    data_out_ready = 4'hF;
    $display("test_reset_mid_dispense done");
  endtask

  initial begin
    rst            = 1'b1;
    data_in        = '0;
    data_in_valid  = '0;
    data_out_ready = '0;
    rotate_amount  = '0;
    rotate_left    = 1'b0;
    rounds         = '0;
    test_reset();
    test_basic_left();
    test_staggered_right();
    test_multi_round();
    test_backpressure();
    test_modulo_edges();
    test_reset_mid_dispense();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
